// File: rtl/spi_sched_pkg.sv
// Shared constants, FSM state type and header helpers for the SPI transfer scheduler.
package spi_sched_pkg;

   localparam logic [7:0] CMD_NON      = 8'd0;
   localparam logic [7:0] CMD_CSR_WR   = 8'd1;
   localparam logic [7:0] CMD_CSR_RD   = 8'd2;
   localparam logic [7:0] CMD_PSRAM_WR = 8'd3;

   localparam int HDR_BYTES   = 8;
   localparam int SPI_MAX_LEN = 2048;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      HDR,
      DATA,
      HOLD,
      GAP
   } schedState_t;

   // Header byte at position idx: address MSB first, cmd, 16-bit length MSB first, dummy.
   function automatic logic [7:0] hdrByte(input logic [2:0] idx, input logic [31:0] adrs,
                                          input logic [7:0] cmd, input logic [15:0] len);
      logic [7:0] b;
      case (idx)
         3'd0:    b = adrs[31:24];
         3'd1:    b = adrs[23:16];
         3'd2:    b = adrs[15:8];
         3'd3:    b = adrs[7:0];
         3'd4:    b = cmd;
         3'd5:    b = len[15:8];
         3'd6:    b = len[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // Only the three defined commands start a transaction.
   function automatic logic cmdValid(input logic [7:0] cmd);
      return (cmd == CMD_CSR_WR) || (cmd == CMD_CSR_RD) || (cmd == CMD_PSRAM_WR);
   endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin one-hot arbiter; the search starts at the pointer and the pointer
// advances past the winner whenever the grant is accepted.
module spi_rr_arbiter
#(
   parameter int pReqNum = 2,
   parameter int pIdxW   = 1
)
(
   input  logic               iSysClk,
   input  logic               iSysRst,
   input  logic [pReqNum-1:0] iReq,
   input  logic               iAccept,
   output logic [pReqNum-1:0] oGrant,
   output logic [pIdxW-1:0]   oIdx,
   output logic               oValid
);

   logic [pIdxW-1:0] ptrReg;

   // Walk offsets from farthest to nearest so the nearest request at/after the pointer wins.
   always_comb begin
      int j;
      j      = 0;
      oGrant = '0;
      oIdx   = '0;
      oValid = 1'b0;
      for (int k = pReqNum - 1; k >= 0; k--) begin
         j = int'(ptrReg) + k;
         if (j >= pReqNum) j = j - pReqNum;
         if (iReq[j]) begin
            oGrant    = '0;
            oGrant[j] = 1'b1;
            oIdx      = pIdxW'(j);
            oValid    = 1'b1;
         end
      end
   end

   // Pointer moves to winner+1 (wrapping) on every accepted grant.
   always_ff @(posedge iSysClk or negedge iSysRst) begin
      if (!iSysRst) begin
         ptrReg <= '0;
      end else if (iAccept && oValid) begin
         ptrReg <= (int'(oIdx) == pReqNum - 1) ? '0 : oIdx + 1'b1;
      end
   end

endmodule

// File: rtl/spi_xfer_sched.sv
// Shares the SPI byte engine between requesters: arbitration, CS framing,
// header generation, data phase and timeout/abort handling.
module spi_xfer_sched
   import spi_sched_pkg::*;
#(
   parameter int pReqNum  = 2,
   parameter int pLenBit  = 12,
   parameter int pCsSetup = 4,
   parameter int pCsHold  = 4,
   parameter int pCsGap   = 8,
   parameter int pTimeout = 1024
)
(
   input  logic                       iSysClk,
   input  logic                       iSysRst,
   input  logic                       iEnable,
   input  logic [pReqNum-1:0]         iReq,
   input  logic [pReqNum*32-1:0]      iReqAdrs,
   input  logic [pReqNum*8-1:0]       iReqCmd,
   input  logic [pReqNum*pLenBit-1:0] iReqLen,
   input  logic [pReqNum*8-1:0]       iReqWd,
   output logic [pReqNum-1:0]         oGrant,
   output logic [pReqNum-1:0]         oWdAck,
   output logic [7:0]                 oRd,
   output logic [pReqNum-1:0]         oRdVd,
   output logic [pReqNum-1:0]         oDone,
   output logic                       oErr,
   output logic                       oSpiCs,
   output logic [7:0]                 oEngTx,
   output logic                       oEngStart,
   input  logic                       iEngDone,
   input  logic [7:0]                 iEngRx
);

   localparam int cIdxW = (pReqNum > 1) ? $clog2(pReqNum) : 1;
   localparam int cCntW = pLenBit + 1;
   localparam logic [15:0]      cSetupLast = 16'(pCsSetup - 1);
   localparam logic [15:0]      cHoldLast  = 16'(pCsHold - 1);
   localparam logic [15:0]      cGapLast   = 16'(pCsGap - 1);
   localparam logic [31:0]      cToLast    = 32'(pTimeout - 1);
   localparam logic [cCntW-1:0] cHdrCnt    = cCntW'(HDR_BYTES);
   localparam logic [cCntW-1:0] cMaxLen    = cCntW'(SPI_MAX_LEN);

   // Per-requester views of the flat request buses.
   logic [31:0]        adrsArr [pReqNum];
   logic [7:0]         cmdArr  [pReqNum];
   logic [pLenBit-1:0] lenArr  [pReqNum];
   logic [7:0]         wdArr   [pReqNum];

   genvar gi;
   generate
      for (gi = 0; gi < pReqNum; gi++) begin : gUnpack
         assign adrsArr[gi] = iReqAdrs[gi*32 +: 32];
         assign cmdArr[gi]  = iReqCmd[gi*8 +: 8];
         assign lenArr[gi]  = iReqLen[gi*pLenBit +: pLenBit];
         assign wdArr[gi]   = iReqWd[gi*8 +: 8];
      end
   endgenerate

   schedState_t        stateReg, stateNext;
   logic [15:0]        cntReg;
   logic [31:0]        toCntReg;
   logic [cCntW-1:0]   byteCntReg;
   logic               busyReg;
   logic               errFlagReg;
   logic [31:0]        adrsReg;
   logic [7:0]         cmdReg;
   logic [pLenBit-1:0] lenReg;
   logic [cIdxW-1:0]   gIdxReg;
   logic [pReqNum-1:0] grantReg, wdAckReg, rdVdReg, doneReg;
   logic [7:0]         rdReg, txReg;
   logic               errReg, csReg, startReg;

   logic [pReqNum-1:0] arbGrant;
   logic [cIdxW-1:0]   arbIdx;
   logic               arbValid;

   logic grantGo, rejectGo, issueByte, endXfer, setErr, engAck, timeoutHit, reqOk;
   logic [cCntW-1:0] phaseTarget;

   spi_rr_arbiter #(.pReqNum(pReqNum), .pIdxW(cIdxW)) uArb (
      .iSysClk (iSysClk),
      .iSysRst (iSysRst),
      .iReq    (iReq),
      .iAccept (grantGo | rejectGo),
      .oGrant  (arbGrant),
      .oIdx    (arbIdx),
      .oValid  (arbValid)
   );

   assign reqOk       = cmdValid(cmdArr[arbIdx]) && ({1'b0, lenArr[arbIdx]} <= cMaxLen);
   assign phaseTarget = (stateReg == HDR) ? cHdrCnt : {1'b0, lenReg};

   // Next-state and per-cycle control strobes.
   always_comb begin
      stateNext  = stateReg;
      grantGo    = 1'b0;
      rejectGo   = 1'b0;
      issueByte  = 1'b0;
      endXfer    = 1'b0;
      setErr     = 1'b0;
      engAck     = iEngDone && busyReg;
      timeoutHit = busyReg && !iEngDone && (toCntReg == cToLast);
      case (stateReg)
         IDLE: begin
            // A done pulse in flight means its requester has not yet dropped iReq.
            if (iEnable && arbValid && (doneReg == '0)) begin
               if (reqOk) begin
                  grantGo   = 1'b1;
                  stateNext = SETUP;
               end else begin
                  rejectGo = 1'b1;
               end
            end
         end
         SETUP: begin
            if (!iEnable) begin
               setErr    = 1'b1;
               stateNext = HOLD;
            end else if (cntReg == cSetupLast) begin
               stateNext = HDR;
            end
         end
         HDR, DATA: begin
            if (timeoutHit) begin
               setErr    = 1'b1;
               stateNext = HOLD;
            end else if (!busyReg || engAck) begin
               if (!iEnable) begin
                  setErr    = 1'b1;
                  stateNext = HOLD;
               end else if (engAck && (byteCntReg == phaseTarget)) begin
                  stateNext = (stateReg == HDR && lenReg != '0) ? DATA : HOLD;
               end else if (!busyReg && (byteCntReg != phaseTarget)) begin
                  issueByte = 1'b1;
               end
            end
         end
         HOLD: begin
            if (cntReg == cHoldLast) begin
               endXfer   = 1'b1;
               stateNext = GAP;
            end
         end
         GAP: begin
            if (cntReg == cGapLast) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge iSysClk or negedge iSysRst) begin
      if (!iSysRst) stateReg <= IDLE;
      else          stateReg <= stateNext;
   end

   // Datapath: latched request, counters, byte handshake and registered outputs.
   always_ff @(posedge iSysClk or negedge iSysRst) begin
      if (!iSysRst) begin
         cntReg     <= '0;
         toCntReg   <= '0;
         byteCntReg <= '0;
         busyReg    <= 1'b0;
         errFlagReg <= 1'b0;
         adrsReg    <= '0;
         cmdReg     <= CMD_NON;
         lenReg     <= '0;
         gIdxReg    <= '0;
         grantReg   <= '0;
         wdAckReg   <= '0;
         rdVdReg    <= '0;
         doneReg    <= '0;
         rdReg      <= '0;
         txReg      <= '0;
         errReg     <= 1'b0;
         csReg      <= 1'b1;
         startReg   <= 1'b0;
      end else begin
         startReg <= 1'b0;
         wdAckReg <= '0;
         rdVdReg  <= '0;
         doneReg  <= '0;
         errReg   <= 1'b0;
         cntReg   <= (stateNext != stateReg) ? '0 : cntReg + 1'b1;
         if (stateNext != stateReg) byteCntReg <= '0;
         if (busyReg) toCntReg <= toCntReg + 1'b1;

         if (grantGo || rejectGo) begin
            adrsReg <= adrsArr[arbIdx];
            cmdReg  <= cmdArr[arbIdx];
            lenReg  <= lenArr[arbIdx];
            gIdxReg <= arbIdx;
         end
         if (grantGo) begin
            grantReg   <= arbGrant;
            csReg      <= 1'b0;
            errFlagReg <= 1'b0;
         end
         if (rejectGo) begin
            doneReg <= arbGrant;
            errReg  <= 1'b1;
         end
         if (setErr) errFlagReg <= 1'b1;

         if (issueByte) begin
            startReg   <= 1'b1;
            busyReg    <= 1'b1;
            toCntReg   <= '0;
            byteCntReg <= byteCntReg + 1'b1;
            if (stateReg == HDR) begin
               txReg <= hdrByte(byteCntReg[2:0], adrsReg, cmdReg, 16'(lenReg));
            end else if (cmdReg == CMD_CSR_RD) begin
               txReg <= 8'h00;
            end else begin
               txReg    <= wdArr[gIdxReg];
               wdAckReg <= grantReg;
            end
         end

         if (engAck || timeoutHit) busyReg <= 1'b0;
         if (engAck && stateReg == DATA && cmdReg == CMD_CSR_RD) begin
            rdReg   <= iEngRx;
            rdVdReg <= grantReg;
         end

         if (endXfer) begin
            csReg    <= 1'b1;
            doneReg  <= grantReg;
            errReg   <= errFlagReg;
            grantReg <= '0;
         end
      end
   end

   assign oGrant    = grantReg;
   assign oWdAck    = wdAckReg;
   assign oRd       = rdReg;
   assign oRdVd     = rdVdReg;
   assign oDone     = doneReg;
   assign oErr      = errReg;
   assign oSpiCs    = csReg;
   assign oEngTx    = txReg;
   assign oEngStart = startReg;

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Directed bench for spi_xfer_sched with a simple byte-engine model and output monitor.
module tb_spi_xfer_sched;

   localparam int pReqNum  = 2;
   localparam int pLenBit  = 12;
   localparam int pCsSetup = 4;
   localparam int pCsHold  = 4;
   localparam int pCsGap   = 8;
   localparam int pTimeout = 1024;

   logic sysClk = 1'b0;
   logic sysRst = 1'b1;
   logic enable;
   logic [pReqNum-1:0]         req;
   logic [pReqNum*32-1:0]      reqAdrs;
   logic [pReqNum*8-1:0]       reqCmd;
   logic [pReqNum*pLenBit-1:0] reqLen;
   logic [pReqNum*8-1:0]       reqWd;
   logic [pReqNum-1:0]         grant, wdAck, rdVd, done;
   logic [7:0]                 rd, engTx, engRx;
   logic                       err, spiCs, engStart, engDone;

   always #5 sysClk = ~sysClk;

   spi_xfer_sched #(
      .pReqNum(pReqNum), .pLenBit(pLenBit), .pCsSetup(pCsSetup),
      .pCsHold(pCsHold), .pCsGap(pCsGap), .pTimeout(pTimeout)
   ) dut (
      .iSysClk(sysClk), .iSysRst(sysRst), .iEnable(enable), .iReq(req),
      .iReqAdrs(reqAdrs), .iReqCmd(reqCmd), .iReqLen(reqLen), .iReqWd(reqWd),
      .oGrant(grant), .oWdAck(wdAck), .oRd(rd), .oRdVd(rdVd), .oDone(done), .oErr(err),
      .oSpiCs(spiCs), .oEngTx(engTx), .oEngStart(engStart), .iEngDone(engDone), .iEngRx(engRx)
   );

   int testsRun = 0;
   int testsFailed = 0;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      if (obs !== exp) begin
         testsFailed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] rxByte(input int i);
      case (i)
         0:       return 8'hAA;
         1:       return 8'hBB;
         2:       return 8'hCC;
         default: return 8'hDD;
      endcase
   endfunction

   // ---------------- engine model: answers each byte two cycles after start ----------------
   int stallIdx = -1;
   int engIdx, engDelay;
   logic engArmed;
   logic [7:0] engPendRx;
   initial begin
      engDone = 1'b0; engRx = 8'h00; engIdx = 0; engDelay = 0; engArmed = 1'b0; engPendRx = 8'h00;
      forever begin
         @(posedge sysClk); #1;
         engDone = 1'b0;
         if (engArmed) begin
            if (engDelay == 0) begin
               engDone = 1'b1; engRx = engPendRx; engArmed = 1'b0;
            end else begin
               engDelay--;
            end
         end
         if (spiCs) engIdx = 0;
         if (engStart) begin
            if (engIdx != stallIdx) begin
               engArmed  = 1'b1;
               engDelay  = 1;
               engPendRx = (engIdx >= 8) ? rxByte((engIdx - 8) % 4) : 8'h55;
            end
            engIdx++;
         end
      end
   end

   // ---------------- monitor and FWFT write-data source for requester 0 ----------------
   int cyc, startCnt, startCsHigh, wdAck0Cnt, rdVd0Cnt, doneCnt, csLowCnt, minGap, highRun;
   int lastStartCyc, lastDoneCyc;
   logic seenLow, lastErr, lastCsAtDone;
   logic [pReqNum-1:0] lastDone, prevGrant;
   logic [1:0] wdPtr;
   logic [7:0] txQ[$];
   logic [7:0] rdQ[$];
   int grantQ[$];
   initial begin
      cyc = 0; startCnt = 0; startCsHigh = 0; wdAck0Cnt = 0; rdVd0Cnt = 0; doneCnt = 0;
      csLowCnt = 0; minGap = 1000000; highRun = 0; lastStartCyc = 0; lastDoneCyc = 0;
      seenLow = 1'b0; lastErr = 1'b0; lastCsAtDone = 1'b0; lastDone = '0; prevGrant = '0;
      wdPtr = 2'd0;
      reqWd = {8'h00, 8'h01};
      forever begin
         @(posedge sysClk); #1;
         cyc++;
         if (!sysRst) begin
            seenLow = 1'b0; highRun = 0; prevGrant = '0;
         end else begin
            if (engStart) begin
               txQ.push_back(engTx); startCnt++; lastStartCyc = cyc;
               if (spiCs) startCsHigh++;
            end
            if (wdAck[0]) begin
               wdAck0Cnt++; wdPtr = wdPtr + 2'd1;
               reqWd[7:0] = 8'({6'd0, wdPtr}) + 8'd1;
            end
            if (rdVd[0]) begin
               rdVd0Cnt++; rdQ.push_back(rd);
            end
            if (done != '0) begin
               doneCnt++; lastDone = done; lastErr = err; lastCsAtDone = spiCs; lastDoneCyc = cyc;
            end
            if (grant != '0 && prevGrant == '0) begin
               for (int i = 0; i < pReqNum; i++) if (grant[i]) grantQ.push_back(i);
            end
            prevGrant = grant;
            if (spiCs) begin
               highRun++;
            end else begin
               if (seenLow && highRun > 0 && highRun < minGap) minGap = highRun;
               highRun = 0; seenLow = 1'b1; csLowCnt++;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   int doneBase, txBase, wdBase, rdBase, rdCntBase, startBase, csHighBase, csLowBase, grBase;

   task automatic snap();
      doneBase = doneCnt; txBase = txQ.size(); wdBase = wdAck0Cnt; rdBase = rdQ.size();
      rdCntBase = rdVd0Cnt; startBase = startCnt; csHighBase = startCsHigh;
      csLowBase = csLowCnt; grBase = grantQ.size();
   endtask

   task automatic startReq(input int r, input logic [31:0] a, input logic [7:0] c,
                           input logic [pLenBit-1:0] l);
      reqAdrs[r*32 +: 32]          = a;
      reqCmd[r*8 +: 8]             = c;
      reqLen[r*pLenBit +: pLenBit] = l;
      req[r]                       = 1'b1;
   endtask

   task automatic waitDone(input int base, input int budget);
      int n;
      n = 0;
      while (doneCnt <= base && n < budget) begin
         @(negedge sysClk); n++;
      end
      if (doneCnt <= base) checkVal("doneTimeout", 32'd0, 32'd1);
   endtask

   task automatic doReq(input int r, input logic [31:0] a, input logic [7:0] c,
                        input logic [pLenBit-1:0] l, input int budget);
      snap();
      startReq(r, a, c, l);
      waitDone(doneBase, budget);
      req[r] = 1'b0;
      $display("[TB] xfer req%0d cmd=%0d len=%0d bytes=%0d done=%b err=%b",
               r, c, l, txQ.size() - txBase, lastDone, lastErr);
   endtask

   logic [7:0] expTx [12] = '{8'h87, 8'h65, 8'h03, 8'h04, 8'h01, 8'h00,
                              8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
   logic [7:0] expRd [4]  = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      enable = 1'b0; req = '0; reqAdrs = '0; reqCmd = '0; reqLen = '0;
      #2 sysRst = 1'b0;
      repeat (3) @(negedge sysClk);
      checkVal("rstCs",    32'(spiCs), 32'd1);
      checkVal("rstGrant", 32'(grant), 32'd0);
      checkVal("rstStart", 32'(engStart), 32'd0);
      checkVal("rstDone",  32'({err, done}), 32'd0);
      sysRst = 1'b1;

      // iEnable=0 must block grants even with both requesters waiting.
      snap();
      startReq(0, 32'h1111_0000, 8'd2, 12'd1);
      startReq(1, 32'h2222_0000, 8'd2, 12'd1);
      repeat (20) @(negedge sysClk);
      checkVal("disGrant", 32'(grantQ.size() - grBase), 32'd0);
      checkVal("disCsLow", 32'(csLowCnt - csLowBase), 32'd0);

      // Both requesters asserted together and held: grants alternate 0,1,0,1.
      enable = 1'b1;
      for (int t = 0; t < 4; t++) begin
         n = doneCnt;
         waitDone(n, 400);
         checkVal($sformatf("altDone%0d", t), 32'(lastDone), (t % 2 == 0) ? 32'd1 : 32'd2);
         $display("[TB] xfer alternate #%0d done=%b err=%b", t, lastDone, lastErr);
      end
      req = '0;
      for (int t = 0; t < 4; t++) begin
         if (grantQ.size() > grBase + t)
            checkVal($sformatf("altGrant%0d", t), 32'(grantQ[grBase + t]), 32'(t % 2));
         else
            checkVal($sformatf("altGrantSeen%0d", t), 32'd0, 32'd1);
      end
      checkVal("csGapMin", 32'(minGap >= pCsGap), 32'd1);

      // CSR write of 4 bytes.
      doReq(0, 32'h8765_0304, 8'd1, 12'd4, 400);
      checkVal("wrBytes", 32'(txQ.size() - txBase), 32'd12);
      for (int i = 0; i < 12; i++)
         if (txQ.size() > txBase + i)
            checkVal($sformatf("wrTx%0d", i), 32'(txQ[txBase + i]), 32'(expTx[i]));
      checkVal("wrAcks",   32'(wdAck0Cnt - wdBase), 32'd4);
      checkVal("wrCsLow",  32'(startCsHigh - csHighBase), 32'd0);
      checkVal("wrDone",   32'(lastDone), 32'd1);
      checkVal("wrErr",    32'(lastErr), 32'd0);
      checkVal("wrCsDone", 32'(lastCsAtDone), 32'd1);

      // CSR read of 4 bytes; only data-phase bytes produce oRdVd.
      doReq(0, 32'h0000_1000, 8'd2, 12'd4, 400);
      checkVal("rdPulses", 32'(rdVd0Cnt - rdCntBase), 32'd4);
      for (int i = 0; i < 4; i++)
         if (rdQ.size() > rdBase + i)
            checkVal($sformatf("rdVal%0d", i), 32'(rdQ[rdBase + i]), 32'(expRd[i]));
      if (txQ.size() > txBase + 8) checkVal("rdTxZero", 32'(txQ[txBase + 8]), 32'd0);
      checkVal("rdErr", 32'(lastErr), 32'd0);

      // Oversized length is rejected without any CS activity.
      doReq(0, 32'h0000_2000, 8'd1, 12'd2049, 50);
      checkVal("rejLenErr",   32'({lastDone, lastErr}), 32'b011);
      checkVal("rejLenCs",    32'(csLowCnt - csLowBase), 32'd0);
      checkVal("rejLenStart", 32'(startCnt - startBase), 32'd0);

      // Unknown command is rejected the same way.
      doReq(0, 32'h0000_3000, 8'd5, 12'd4, 50);
      checkVal("rejCmdErr", 32'({lastDone, lastErr}), 32'b011);
      checkVal("rejCmdCs",  32'(csLowCnt - csLowBase), 32'd0);

      // Zero length: header only.
      doReq(0, 32'h0000_4000, 8'd2, 12'd0, 400);
      checkVal("len0Bytes", 32'(txQ.size() - txBase), 32'd8);
      if (txQ.size() >= txBase + 8)
         checkVal("len0Len", 32'({txQ[txBase + 5], txQ[txBase + 6]}), 32'd0);
      checkVal("len0Err", 32'(lastErr), 32'd0);

      // Engine never answers the 3rd header byte: timeout, then hold, then error done.
      stallIdx = 2;
      doReq(0, 32'h0000_5000, 8'd2, 12'd4, 3000);
      stallIdx = -1;
      checkVal("toErr",    32'(lastErr), 32'd1);
      checkVal("toBytes",  32'(txQ.size() - txBase), 32'd3);
      checkVal("toCsDone", 32'(lastCsAtDone), 32'd1);
      checkVal("toWindow", 32'((lastDoneCyc - lastStartCyc >= pTimeout + pCsHold) &&
                               (lastDoneCyc - lastStartCyc <= pTimeout + pCsHold + 2)), 32'd1);
      doReq(0, 32'h0000_6000, 8'd2, 12'd1, 400);
      checkVal("postToErr",   32'(lastErr), 32'd0);
      checkVal("postToBytes", 32'(txQ.size() - txBase), 32'd9);

      // Reset in the middle of DATA; pointer must restart from 0.
      snap();
      startReq(0, 32'h0000_7000, 8'd2, 12'd4);
      n = 0;
      while (startCnt - startBase < 10 && n < 500) begin
         @(negedge sysClk); n++;
      end
      checkVal("reachData", 32'(startCnt - startBase >= 10), 32'd1);
      startReq(1, 32'h0000_8000, 8'd2, 12'd1);
      @(negedge sysClk);
      sysRst = 1'b0;
      #1;
      checkVal("midRstCs",     32'(spiCs), 32'd1);
      checkVal("midRstPulses", 32'({engStart, wdAck, rdVd, done, err}), 32'd0);
      checkVal("midRstGrant",  32'(grant), 32'd0);
      repeat (3) @(negedge sysClk);
      checkVal("midRstNoDone", 32'(doneCnt - doneBase), 32'd0);
      grBase = grantQ.size();
      sysRst = 1'b1;
      n = 0;
      while (grantQ.size() <= grBase && n < 50) begin
         @(negedge sysClk); n++;
      end
      if (grantQ.size() > grBase) checkVal("regrantIdx", 32'(grantQ[grBase]), 32'd0);
      else                        checkVal("regrantSeen", 32'd0, 32'd1);
      n = doneCnt;
      waitDone(n, 400);
      req[0] = 1'b0;
      checkVal("regrantDone0", 32'({lastDone, lastErr}), 32'b010);
      $display("[TB] xfer req0 after reset done=%b err=%b", lastDone, lastErr);
      n = doneCnt;
      waitDone(n, 400);
      req[1] = 1'b0;
      checkVal("regrantDone1", 32'({lastDone, lastErr}), 32'b100);
      $display("[TB] xfer req1 after reset done=%b err=%b", lastDone, lastErr);

      repeat (5) @(negedge sysClk);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/spi_xfer_sched.md
Name: spi_xfer_sched

Overview:
- Schedules and shares the FPGA SPI master byte engine between pReqNum on-chip requesters, e.g. CSR bridge and PSRAM loader.
- Each granted request becomes one CS-framed transaction in the team's SPI frame format: 4-byte address, cmd, 2-byte length, dummy byte, then nData bytes.
- Sits between the requesters and the SPI engine. Owns chip-select timing, round-robin arbitration, header generation and error/timeout handling.

Parameters:
- pReqNum, 2, number of requesters (2..8).
- pLenBit, 12, request length width; legal lengths are 0..2048 bytes.
- pCsSetup, 4, cycles CS is held low before the first byte.
- pCsHold, 4, cycles CS stays low after the last byte.
- pCsGap, 8, minimum CS-high cycles between transactions.
- pTimeout, 1024, max cycles from oEngStart to iEngDone.

Ports:
- iSysClk  in  1  system clock.
- iSysRst  in  1  reset, asynchronous, active-low.
- iEnable  in  1  1 = FPGA acts as SPI master (monopoly granted); 0 = no new grants.
- iReq  in  pReqNum  per-requester request level.
- iReqAdrs  in  pReqNum*32  per-requester 32-bit target address.
- iReqCmd  in  pReqNum*8  per-requester command: 1 Csr Write, 2 Csr Read, 3 PSRAM Write.
- iReqLen  in  pReqNum*pLenBit  per-requester data byte count.
- iReqWd  in  pReqNum*8  per-requester write byte, first-word-fall-through.
- oGrant  out  pReqNum  one-hot; high for the whole transaction.
- oWdAck  out  pReqNum  1-cycle pulse; write byte consumed.
- oRd  out  8  read byte.
- oRdVd  out  pReqNum  1-cycle pulse; oRd valid for that requester.
- oDone  out  pReqNum  1-cycle pulse; transaction ended.
- oErr  out  1  valid with oDone: 1 = rejected, timeout or abort.
- oSpiCs  out  1  chip select, active-low.
- oEngTx  out  8  byte to shift out.
- oEngStart  out  1  1-cycle pulse; engine starts one byte.
- iEngDone  in  1  1-cycle pulse; byte finished, iEngRx valid.
- iEngRx  in  8  byte shifted in.

Behaviour:
- Reset values: oSpiCs=1. All other outputs 0. FSM=IDLE. Round-robin pointer=0. Asserting reset mid-transaction raises CS in the same instant; no oDone is issued.
- FSM states: IDLE, SETUP, HDR, DATA, HOLD, GAP.
- IDLE → SETUP:
  - Requires iEnable=1 and any iReq.
  - Grant goes to the lowest index at or above the pointer, wrapping. The pointer then moves to grant+1 mod pReqNum.
  - Adrs, cmd and len are latched on the grant cycle. oSpiCs falls in the next cycle.
  - Requesters keep iReq high until oDone. iReq is ignored while granted.
- Grant-cycle rejection:
  - Triggered by len>2048 or cmd not in {1,2,3}.
  - Result: no CS activity, oDone[g]=1 and oErr=1 in the next cycle, FSM returns to IDLE.
- SETUP: counts pCsSetup cycles, then → HDR.
- HDR sends 8 bytes in this order: adrs[31:24], adrs[23:16], adrs[15:8], adrs[7:0], cmd, len[15:8], len[7:0] (len zero-extended to 16 bits), 0x00.
- Byte handshake:
  - oEngStart pulses with oEngTx stable for that cycle.
  - The next oEngStart comes no earlier than 1 cycle after iEngDone.
  - iEngDone with no byte outstanding is ignored.
- DATA:
  - Runs len bytes; len=0 skips straight to HOLD.
  - cmd 1/3: oEngTx=iReqWd[g]. oWdAck[g] pulses in the same cycle as oEngStart.
  - cmd 2: oEngTx=0x00. On iEngDone, oRd=iEngRx and oRdVd[g]=1 in the next cycle.
  - Byte counter is pLenBit+1 bits wide, so 2048 does not wrap.
- HOLD: pCsHold cycles. Then oSpiCs=1, oDone[g]=1, grant is released → GAP.
- GAP: pCsGap cycles with CS high → IDLE. Arbitration resumes only in IDLE.
- Timeout: iEngDone absent for pTimeout cycles after oEngStart → go directly to HOLD with oErr=1 at oDone.
- iEnable falling mid-transaction: the current byte completes, then → HOLD with oErr=1. In IDLE, iEnable=0 blocks any grant.
- Simultaneous events: a new iReq during GAP waits. Requests arriving together resolve by the pointer.

Decomposition:
- Package spi_sched_pkg holds:
  - cmd constants: CMD_NON=0, CMD_CSR_WR=1, CMD_CSR_RD=2, CMD_PSRAM_WR=3;
  - FSM state enum;
  - HDR_BYTES=8;
  - SPI_MAX_LEN=2048.
- One sub-module, spi_rr_arbiter: round-robin one-hot grant from an iReq vector, with pointer update on accept.

Test Plan:
- Req0 with adrs=0x8765_0304, cmd=1, len=4, wd=01,02,03,04 → oEngTx sequence 87,65,03,04,01,00,04,00,01,02,03,04. oWdAck[0] pulses ×4. CS low across all 12 bytes. oDone[0]=1 with oErr=0.
- Req0 with cmd=2, len=4, engine returns AA,BB,CC,DD in the data phase → oRdVd[0] pulses ×4 with oRd=AA,BB,CC,DD. Header bytes produce no oRdVd.
- Req0 and Req1 asserted in the same cycle, continuously, for 4 transactions → grants alternate 0,1,0,1. Between transactions CS is high for ≥pCsGap cycles.
- Req with len=2049, then len=0 → first: oDone+oErr with CS never low. Second: only 8 header bytes, then oDone with oErr=0.
- Engine withholds iEngDone after the 3rd header byte → after pTimeout cycles CS rises following pCsHold, oDone with oErr=1, next request served normally.
- iSysRst low mid-DATA → oSpiCs=1 immediately, all pulses 0. After release, the pending iReq is re-granted from pointer 0.
